// File: rtl/rs232_pkg.sv
// Shared rs232 definitions: FSM encoding, default bit period, frame sizes.
// RS232_XMIT_PARITY_EN adds the PARITY state (8E1 frame instead of 8N1).
package rs232_pkg;

  localparam int DEFAULT_PERIOD = 1250;
  localparam int FRAME_BITS_8N1 = 10;
  localparam int FRAME_BITS_8E1 = 11;

`ifdef RS232_XMIT_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_t;
`endif

  function automatic int frame_bits();
`ifdef RS232_XMIT_PARITY_EN
    return FRAME_BITS_8E1;
`else
    return FRAME_BITS_8N1;
`endif
  endfunction

endpackage

// File: rtl/rs232_fifo.sv
// Byte FIFO in front of the serializer; DEPTH must be a power of two >= 2.
// Pushes when full and pops when empty are ignored.
module rs232_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [7:0]             wr_data,
  input  logic                   pop,
  output logic [7:0]             rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  // Qualify requests and advance pointers/occupancy.
  always_comb begin
    full     = (count_q == FULL_CNT);
    empty    = (count_q == '0);
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

endmodule

// File: rtl/rs232_xmit.sv
// RS-232 transmitter: byte FIFO plus LSB-first serializer, PERIOD clocks/bit.
// Defining RS232_XMIT_PARITY_EN inserts an even-parity bit (8E1 frame).
module rs232_xmit
  import rs232_pkg::*;
#(
  parameter int PERIOD = DEFAULT_PERIOD,
  parameter int DEPTH  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       TX,
  output logic       busy
);

  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    data_q, data_d;
  logic          tx_q, tx_d;
  logic          bit_end;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_head;
  logic [AW:0]   fifo_count;

  rs232_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (tx_valid),
    .wr_data (tx_data),
    .pop     (fifo_pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Frame sequencing; a queued byte is loaded straight out of STOP.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    data_d   = data_q;
    fifo_pop = 1'b0;
    bit_end  = (cnt_q == CNT_LAST);
    if (state_q != ST_IDLE)
      cnt_d = bit_end ? '0 : cnt_q + CW'(1);
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          data_d   = fifo_head;
          cnt_d    = '0;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          idx_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7)
`ifdef RS232_XMIT_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
        end
      end
`ifdef RS232_XMIT_PARITY_EN
      ST_PARITY: begin
        if (bit_end) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (bit_end) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            data_d   = fifo_head;
            state_d  = ST_START;
          end else begin
            state_d  = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Line level for the coming cycle, so TX itself is a clean flop.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = data_d[idx_d];
`ifdef RS232_XMIT_PARITY_EN
      ST_PARITY: tx_d = ^data_d;
`endif
      default:   tx_d = 1'b1;
    endcase
  end

  // Serializer state; reset aborts any frame and idles the line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
    end
  end

  assign TX       = tx_q;
  assign tx_ready = ~fifo_full;
  assign busy     = (state_q != ST_IDLE) | (fifo_count != '0);

endmodule

// File: tb/tb_rs232_xmit.sv
// Randomized bench for rs232_xmit: timeline model plus line-decoding scoreboard.
// Honors RS232_XMIT_PARITY_EN for the expected frame layout.
module tb_rs232_xmit;

  localparam int P = 4;
  localparam int D = 4;
`ifdef RS232_XMIT_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       TX;
  logic       busy;

  rs232_xmit #(
    .PERIOD (P),
    .DEPTH  (D)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .TX       (TX),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    $display("FAIL %s: bound expired at %0t", nm, $time);
  endtask

  // Reference: frame = start 0, data LSB first, [even parity], stop 1.
  function automatic logic [10:0] mk(input logic [7:0] b);
`ifdef RS232_XMIT_PARITY_EN
    return {1'b1, ^b, b, 1'b0};
`else
    return {2'b11, b, 1'b0};
`endif
  endfunction

  logic [7:0]  mq[$];
  logic [7:0]  sb_q[$];
  int          ecnt = 0;
  int          line_end = 0;
  int          fs = -1000;
  logic [10:0] fb = '1;
  logic        exp_tx = 1'b1;
  logic        exp_busy = 1'b0;
  logic        exp_ready = 1'b1;
  logic        chk_en = 1'b0;

  task automatic mclear();
    mq.delete();
    sb_q.delete();
    line_end  = ecnt;
    fs        = -1000;
    exp_tx    = 1'b1;
    exp_busy  = 1'b0;
    exp_ready = 1'b1;
  endtask

  // Timeline model: byte leaves the queue when the line is free.
  always @(posedge clk) begin
    if (reset) begin
      mclear();
    end else begin
      logic rdy;
      logic infr;
      rdy = (mq.size() < D);
      if (mq.size() != 0 && ecnt >= line_end) begin
        fb       = mk(mq.pop_front());
        fs       = ecnt;
        line_end = ecnt + NB * P;
      end
      if (tx_valid && rdy) begin
        mq.push_back(tx_data);
        sb_q.push_back(tx_data);
      end
      infr      = (ecnt >= fs) && (ecnt < fs + NB * P);
      exp_tx    = infr ? fb[(ecnt - fs) / P] : 1'b1;
      exp_busy  = infr || (mq.size() != 0);
      exp_ready = (mq.size() < D);
      ecnt++;
    end
  end

  // Cycle-exact output comparison.
  always @(negedge clk) begin
    if (chk_en && !reset) begin
      chk("tx_line", int'(TX), int'(exp_tx));
      chk("busy", int'(busy), int'(exp_busy));
      chk("tx_ready", int'(tx_ready), int'(exp_ready));
    end
  end

  // Line decoder: samples mid-bit and pops the scoreboard per frame.
  int          dcnt = -1;
  logic [10:0] dbits = '0;

  always @(negedge clk) begin
    if (reset) begin
      dcnt = -1;
    end else begin
      if (dcnt < 0 && TX == 1'b0) dcnt = 0;
      if (dcnt >= 0) begin
        if (dcnt % P == P / 2) dbits[dcnt / P] = TX;
        dcnt++;
        if (dcnt == NB * P) begin
          dcnt = -1;
          if (sb_q.size() == 0) begin
            n_chk++;
            $display("FAIL frame_unexpected: got %02h expected none", dbits[8:1]);
          end else begin
            logic [7:0] e;
            e = sb_q.pop_front();
            chk("frame_data", int'(dbits[8:1]), int'(e));
            chk("start_bit", int'(dbits[0]), 0);
            chk("stop_bit", int'(dbits[NB-1]), 1);
`ifdef RS232_XMIT_PARITY_EN
            chk("parity_bit", int'(dbits[9]), int'(^e));
`endif
          end
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [7:0] d);
    tx_valid = v;
    tx_data  = d;
    @(negedge clk);
  endtask

  task automatic wait_idle(input int lim);
    int n;
    n = 0;
    while ((busy || exp_busy || dcnt >= 0) && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (n >= lim) fail_now("idle_timeout");
  endtask

  initial begin
    #1 reset = 1'b1;
    #1;
    chk("rst_tx", int'(TX), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(tx_ready), 1);
    repeat (3) @(negedge clk);
    reset  = 1'b0;
    chk_en = 1'b1;

    // Single byte on the first edge after reset release.
    drive(1'b1, 8'h31);
    drive(1'b0, 8'h00);
    wait_idle(200);
    chk("idle_tx", int'(TX), 1);
    chk("idle_busy", int'(busy), 0);

    // Back-to-back frames.
    drive(1'b1, 8'h55);
    drive(1'b1, 8'hAA);
    drive(1'b0, 8'h00);
    wait_idle(400);

    // Overfill: one in flight, D queued, next attempt dropped.
    for (int i = 0; i < 5; i++) drive(1'b1, 8'hA0 + 8'(i));
    chk("ready_full", int'(tx_ready), 0);
    drive(1'b1, 8'hEE);
    drive(1'b0, 8'h00);
    wait_idle(1000);

    // Reset in the middle of a data bit.
    begin
      int n;
      drive(1'b1, 8'hC3);
      drive(1'b0, 8'h00);
      n = 0;
      while (TX != 1'b0 && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (n >= 20) fail_now("start_timeout");
      repeat (13) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("abort_tx", int'(TX), 1);
      chk("abort_busy", int'(busy), 0);
      chk("abort_ready", int'(tx_ready), 1);
      mclear();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      drive(1'b1, 8'h5A);
      drive(1'b0, 8'h00);
      wait_idle(200);
    end

    // Push coinciding with pop at count 2, walking pointers round.
    drive(1'b1, 8'h10);
    drive(1'b1, 8'h11);
    drive(1'b1, 8'h12);
    drive(1'b0, 8'h00);
    for (int k = 0; k < 6; k++) begin
      int n;
      n = 0;
      while (ecnt != line_end && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (n >= 200) fail_now("align_timeout");
      drive(1'b1, 8'h20 + 8'(k));
      drive(1'b0, 8'h00);
    end
    wait_idle(1000);

    // Random traffic.
    for (int c = 0; c < 3000; c++)
      drive($urandom_range(0, 5) == 0, 8'($urandom));
    drive(1'b0, 8'h00);
    wait_idle(NB * P * (D + 2) + 20);
    chk("sb_drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rs232_xmit.md
RS232_XMIT -- requirements
Module: rs232_xmit

Interface
REQ-001 SHALL have parameter PERIOD, default 1250, giving clock cycles per bit (12 MHz / 9600 baud).
REQ-002 SHALL have parameter DEPTH, default 4, giving byte FIFO entries (power of two, minimum 2).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port tx_data, input, 8 bits: the byte to send.
REQ-006 SHALL have port tx_valid, input, 1 bit: tx_data is valid this cycle.
REQ-007 SHALL have port tx_ready, output, 1 bit: the FIFO can accept a byte this cycle.
REQ-008 SHALL have port TX, output, 1 bit: the serial line, idle high.
REQ-009 SHALL have port busy, output, 1 bit: a frame is in progress or the FIFO is not empty.

Function
REQ-010 SHALL push tx_data into the FIFO on a clock edge where tx_valid and tx_ready are both 1; a push with tx_ready=0 SHALL be dropped.
REQ-011 SHALL drive tx_ready = (FIFO count < DEPTH), decoded from registered count only, with no combinational path from tx_valid.
REQ-012 SHALL run the state machine IDLE -> START -> DATA -> [PARITY] -> STOP -> (START if FIFO non-empty, else IDLE).
REQ-013 SHALL, in IDLE with the FIFO non-empty, pop the head and enter START on the next edge; TX SHALL go low 1 cycle after the FIFO becomes non-empty.
REQ-014 SHALL hold every bit (start, data, parity, stop) for exactly PERIOD cycles, timed by a bit counter of $clog2(PERIOD) bits that runs from 0 to PERIOD-1 and wraps.
REQ-015 SHALL drive TX as follows: START=0; DATA=bits 0..7, LSB first, counted by a 3-bit index; STOP=1; IDLE=1.
REQ-016 SHALL send back-to-back frames with no idle gap: the last STOP cycle is followed directly by the next START when a byte is queued.
REQ-017 SHALL allow a push and a pop in the same cycle; the count is then unchanged, and FIFO pointers wrap modulo DEPTH.
REQ-018 SHALL register TX (flop output, glitch-free).
REQ-019 SHALL drive busy = (state != IDLE) | (count != 0).

Reset
REQ-020 SHALL, on reset assertion and without waiting for a clock, force TX=1, state=IDLE, FIFO empty (tx_ready=1, busy=0) and all counters=0.
REQ-021 SHALL abort any frame in progress when reset is asserted mid-frame; the partial frame SHALL NOT resume.
REQ-022 SHALL accept its first push on the first clock edge after reset deasserts.

Configuration
REQ-023 SHALL, when RS232_XMIT_PARITY_EN is defined, insert a PARITY state after DATA that drives the even-parity bit (XOR of the 8 data bits), giving an 11-bit frame.
REQ-024 SHALL, when RS232_XMIT_PARITY_EN is undefined, contain no PARITY state or logic and send an 8N1 10-bit frame.

Structure
REQ-025 SHALL take the state enum, default PERIOD and frame-length constants (10 and 11 bits) from shared package rs232_pkg, which rs232_recv also uses.
REQ-026 SHALL implement the FIFO as sub-module rs232_fifo (parameter DEPTH; push/pop/full/empty/count ports); the serializer stays in rs232_xmit.

Verification (PERIOD=4)
REQ-027 SHALL cover: push 0x31 after reset -> TX = 0,1,0,0,0,1,1,0,0,1, each bit 4 cycles, frame 40 cycles; then TX=1 and busy=0.
REQ-028 SHALL cover: push 0x31 with parity enabled -> parity bit 1 inserted before stop; frame 44 cycles. Push 0x03 -> parity bit 0.
REQ-029 SHALL cover: push 0x55 and 0xAA on consecutive cycles -> two frames with no gap; TX falls to start exactly at cycle 40 of the first frame.
REQ-030 SHALL cover: push 5 bytes while the line is idle (DEPTH=4) -> 1 byte popped into the shift stage, 4 queued; tx_ready=0 on the 6th attempt and that byte is dropped.
REQ-031 SHALL cover: reset asserted mid-DATA (cycle 13 of a frame) -> TX=1 immediately, busy=0, tx_ready=1; a fresh push afterwards sends a complete, correct frame.
REQ-032 SHALL cover: push and pop in the same cycle with count=2 -> count stays 2, byte order preserved across pointer wrap.
